// File: rtl/decode_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_hazard_controller_if
// Description : Decode-stage request and hazard-control response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_hazard_controller_if #(
    parameter int ADDR_W = 3
);
    logic                     dec_valid;
    logic [ADDR_W-1:0]        dec_srcA;
    logic                     dec_useA;
    logic [ADDR_W-1:0]        dec_srcB;
    logic                     dec_useB;
    logic                     dec_wren;
    logic [ADDR_W-1:0]        dec_writeAd;
    logic                     exe_pc_load;
    logic                     stall;
    logic                     bubble;
    logic                     issue;
    logic [1:0]               state;
    logic [(1<<ADDR_W)-1:0]   busy_map;
    logic [15:0]              stall_count;

    modport master (
        output dec_valid, dec_srcA, dec_useA, dec_srcB, dec_useB,
               dec_wren, dec_writeAd, exe_pc_load,
        input  stall, bubble, issue, state, busy_map, stall_count
    );

    modport slave (
        input  dec_valid, dec_srcA, dec_useA, dec_srcB, dec_useB,
               dec_wren, dec_writeAd, exe_pc_load,
        output stall, bubble, issue, state, busy_map, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/decode_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : decode_hazard_controller
// Description : RAW-hazard scoreboard, stall/bubble and branch-flush control
//               for the decode-to-execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_hazard_controller #(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 3
) (
    input  wire logic                 CLK,
    input  wire logic                 RST_N,
    decode_hazard_controller_if.slave bus
);
    localparam int         c_NREG       = 1 << ADDR_W;
    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_flush_cnt;
    logic [3:0]            w_flush_cnt_nxt;
    logic [PIPE_DEPTH-1:0] r_sb_v;
    logic [ADDR_W-1:0]     r_sb_addr [PIPE_DEPTH];
    logic [15:0]           r_stall_count;
    logic [c_NREG-1:0]     w_busy;
    logic                  w_hz;
    logic                  w_flushing;
    logic                  w_squash;
    logic                  w_issue;
    logic                  w_stall;

    // The retiring entry still counts: there is no write-through bypass.
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (r_sb_v[k]) begin
                w_busy[r_sb_addr[k]] = 1'b1;
            end
        end
    end

    assign w_hz       = bus.dec_valid &
                        ((bus.dec_useA & w_busy[bus.dec_srcA]) |
                         (bus.dec_useB & w_busy[bus.dec_srcB]));
    assign w_flushing = (r_state == ST_FLUSH);
    assign w_squash   = bus.exe_pc_load & ~w_flushing;
    assign w_issue    = RST_N & bus.dec_valid & ~w_hz & ~w_flushing & ~bus.exe_pc_load;
    assign w_stall    = RST_N & (w_hz | w_flushing | bus.exe_pc_load);

    assign bus.issue       = w_issue;
    assign bus.stall       = w_stall;
    assign bus.bubble      = ~w_issue;
    assign bus.state       = r_state;
    assign bus.busy_map    = RST_N ? w_busy : '0;
    assign bus.stall_count = r_stall_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (bus.exe_pc_load) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_LOAD;
                end else if (w_hz) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= ST_RUN;
            r_flush_cnt   <= 4'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    // A taken PC load kills the younger instruction as it leaves entry 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sb_v <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_sb_addr[k] <= '0;
            end
        end else begin
            r_sb_v[0]    <= w_issue & bus.dec_wren;
            r_sb_addr[0] <= bus.dec_writeAd;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (k == 1) begin
                    r_sb_v[k] <= r_sb_v[0] & ~w_squash;
                end else begin
                    r_sb_v[k] <= r_sb_v[k-1];
                end
                r_sb_addr[k] <= r_sb_addr[k-1];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_hazard_controller
// Description : Directed and randomized self-checking bench with a write-list
//               reference model of the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_hazard_controller;
    localparam int PD = 3;
    localparam int FC = 2;
    localparam int AW = 3;

    typedef struct {
        int addr;
        int age;
    } wr_t;

    logic CLK;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    decode_hazard_controller_if #(.ADDR_W(AW)) bus ();

    decode_hazard_controller #(
        .PIPE_DEPTH   (PD),
        .FLUSH_CYCLES (FC),
        .ADDR_W       (AW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight writes live PD cycles after issue.
    wr_t      m_wr[$];
    wr_t      m_nq[$];
    int       m_flush_left = 0;
    bit       m_stalled    = 0;
    int       m_cnt        = 0;
    bit       m_known      = 0;
    logic [7:0] e_busy;
    bit       e_hz, e_issue, e_stall, e_flushing, e_squash;

    function automatic logic [7:0] model_busy();
        logic [7:0] b = 8'h00;
        foreach (m_wr[i]) b[m_wr[i].addr] = 1'b1;
        return b;
    endfunction

    always @(negedge CLK) begin
        if (!done) begin
            e_flushing = (m_flush_left > 0);
            if (!RST_N) begin
                e_busy  = 8'h00;
                e_hz    = 1'b0;
                e_issue = 1'b0;
                e_stall = 1'b0;
            end else begin
                e_busy  = model_busy();
                e_hz    = bus.dec_valid && ((bus.dec_useA && e_busy[bus.dec_srcA]) ||
                                            (bus.dec_useB && e_busy[bus.dec_srcB]));
                e_issue = bus.dec_valid && !e_hz && !e_flushing && !bus.exe_pc_load;
                e_stall = e_hz || e_flushing || bus.exe_pc_load;
            end
            chk("m_issue",  int'(bus.issue),    int'(e_issue));
            chk("m_stall",  int'(bus.stall),    int'(e_stall));
            chk("m_bubble", int'(bus.bubble),   int'(!e_issue));
            chk("m_busy",   int'(bus.busy_map), int'(e_busy));
            if (m_known) begin
                chk("m_state", int'(bus.state), e_flushing ? 2 : (m_stalled ? 1 : 0));
                chk("m_count", int'(bus.stall_count), m_cnt);
            end
            if (!RST_N) begin
                m_wr.delete();
                m_flush_left = 0;
                m_stalled    = 0;
                m_cnt        = 0;
                m_known      = 1;
            end else begin
                if (e_stall && m_cnt < 65535) m_cnt++;
                e_squash = bus.exe_pc_load && !e_flushing;
                m_nq.delete();
                foreach (m_wr[i]) begin
                    if (!(e_squash && m_wr[i].age == 0) && (m_wr[i].age + 1 < PD))
                        m_nq.push_back('{m_wr[i].addr, m_wr[i].age + 1});
                end
                if (e_issue && bus.dec_wren) m_nq.push_back('{int'(bus.dec_writeAd), 0});
                m_wr = m_nq;
                if (e_flushing) begin
                    m_flush_left--;
                    m_stalled = 0;
                end else if (bus.exe_pc_load) begin
                    m_flush_left = FC;
                    m_stalled    = 0;
                end else begin
                    m_stalled = e_hz;
                end
            end
        end
    end

    task automatic drive(input bit v, input int a, input bit ua, input int b, input bit ub,
                         input bit w, input int wa, input bit pcl);
        @(posedge CLK);
        #1;
        bus.dec_valid   = v;
        bus.dec_srcA    = AW'(a);
        bus.dec_useA    = ua;
        bus.dec_srcB    = AW'(b);
        bus.dec_useB    = ub;
        bus.dec_wren    = w;
        bus.dec_writeAd = AW'(wa);
        bus.exe_pc_load = pcl;
        #2;
    endtask

    task automatic wr(input int r);
        drive(1, 0, 0, 0, 0, 1, r, 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_a(input int r, input bit pcl);
        drive(1, r, 1, 0, 0, 0, 0, pcl);
    endtask

    initial begin
        RST_N = 1'b0;
        bus.dec_valid = 0; bus.dec_srcA = 0; bus.dec_useA = 0; bus.dec_srcB = 0;
        bus.dec_useB = 0; bus.dec_wren = 0; bus.dec_writeAd = 0; bus.exe_pc_load = 0;

        idle();
        drive(1, 0, 0, 0, 0, 1, 1, 1);
        chk("rst_stall",  int'(bus.stall),    0);
        chk("rst_bubble", int'(bus.bubble),   1);
        chk("rst_issue",  int'(bus.issue),    0);
        chk("rst_busy",   int'(bus.busy_map), 0);
        idle();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #2;
        chk("rst_state", int'(bus.state),       0);
        chk("rst_count", int'(bus.stall_count), 0);

        // Independent writer stream
        wr(1); chk("t1_issue", int'(bus.issue), 1); chk("t1_busy0", int'(bus.busy_map), 8'h00);
        wr(2); chk("t1_busy1", int'(bus.busy_map), 8'h02);
        wr(3); chk("t1_busy2", int'(bus.busy_map), 8'h06); chk("t1_stall", int'(bus.stall), 0);
        idle(); chk("t1_busy3", int'(bus.busy_map), 8'h0E);
        idle(); chk("t1_busy4", int'(bus.busy_map), 8'h0C);
        idle(); chk("t1_busy5", int'(bus.busy_map), 8'h08);
        idle(); chk("t1_busy6", int'(bus.busy_map), 8'h00);

        // RAW hazard on srcA
        wr(5);
        rd_a(5, 0); chk("t2_stall0", int'(bus.stall), 1); chk("t2_bub0", int'(bus.bubble), 1);
        rd_a(5, 0); chk("t2_state1", int'(bus.state), 1);
        rd_a(5, 0); chk("t2_stall2", int'(bus.stall), 1);
        rd_a(5, 0); chk("t2_issue", int'(bus.issue), 1); chk("t2_count", int'(bus.stall_count), 3);

        // Unused srcB does not hazard
        wr(5);
        drive(1, 0, 0, 5, 0, 0, 0, 0);
        chk("t3_issue", int'(bus.issue), 1); chk("t3_stall", int'(bus.stall), 0);
        chk("t3_busy", int'(bus.busy_map), 8'h20);

        // Branch flush squashes entry 0
        wr(6);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_busy", int'(bus.busy_map), 8'h60); chk("t4_stall0", int'(bus.stall), 1);
        idle(); chk("t4_state1", int'(bus.state), 2); chk("t4_busy1", int'(bus.busy_map), 8'h00);
        idle(); chk("t4_state2", int'(bus.state), 2); chk("t4_stall2", int'(bus.stall), 1);
        idle(); chk("t4_state3", int'(bus.state), 0); chk("t4_count", int'(bus.stall_count), 6);

        // Hazard coinciding with a PC load
        wr(2);
        rd_a(2, 1); chk("t5_stall", int'(bus.stall), 1); chk("t5_issue0", int'(bus.issue), 0);
        rd_a(2, 0); chk("t5_state", int'(bus.state), 2);
        rd_a(2, 0);
        rd_a(2, 0); chk("t5_state3", int'(bus.state), 0); chk("t5_issue", int'(bus.issue), 1);

        // Reset during a flush
        wr(4); wr(5); idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1); chk("t6_busy", int'(bus.busy_map), 8'h30);
        idle(); chk("t6_state", int'(bus.state), 2); chk("t6_busy1", int'(bus.busy_map), 8'h20);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_stall", int'(bus.stall), 0); chk("t6_rst_busy", int'(bus.busy_map), 0);
        idle();
        RST_N = 1'b1;
        #1;
        chk("t6_state1", int'(bus.state), 0); chk("t6_busy2", int'(bus.busy_map), 0);
        chk("t6_count", int'(bus.stall_count), 0);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            if ($urandom_range(0, 1) == 0) begin
                bus.dec_valid   = ($urandom_range(0, 7) != 0);
                bus.dec_srcA    = AW'($urandom_range(0, 7));
                bus.dec_useA    = $urandom_range(0, 1) == 1;
                bus.dec_srcB    = AW'($urandom_range(0, 7));
                bus.dec_useB    = $urandom_range(0, 1) == 1;
                bus.dec_wren    = ($urandom_range(0, 9) < 7);
                bus.dec_writeAd = AW'($urandom_range(0, 7));
            end
            bus.exe_pc_load = ($urandom_range(0, 9) == 0);
            RST_N           = ($urandom_range(0, 99) != 0);
        end

        // Counter saturation
        idle();
        RST_N = 1'b0;
        idle();
        RST_N = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (65540) @(posedge CLK);
        #3;
        chk("t6_sat", int'(bus.stall_count), 16'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_sat_hold", int'(bus.stall_count), 16'hFFFF);

        @(posedge CLK);
        #3;
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
